// File: rtl/sram_sync.sv
// sram_sync: parametrised synchronous single-port SRAM with a registered read,
// a read-valid strobe, selectable read-during-write behaviour and a
// post-reset zero-fill sequencer.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   cs         chip select; wr/rd are ignored when low
//   wr, rd     write / read strobes, level-sampled at every rising edge
//   addr       word address (full 2**ADDR_W depth, always in range)
//   din        write data
//   dout       registered read data; holds until the next read
//   dout_valid one-cycle pulse: dout was updated by the previous edge
//   busy       zero-fill in progress; accesses are refused
//   rejected   one-cycle pulse: an access was attempted while busy
//
// FSM states:
//   state   | meaning
//   S_CLEAR | zero-filling mem[ptr], one location per cycle; busy=1
//   S_IDLE  | normal read/write service

module sram_sync #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter bit RDW_MODE       = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              rejected
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  logic              access;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_fire;
  logic              rej_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  assign access = cs & (wr | rd);
  assign busy   = (state == S_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = din;
    rd_fire   = 1'b0;
    rej_nxt   = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
        rej_nxt   = access;
        // The last location is written on the same edge that leaves CLEAR,
        // so busy drops exactly DEPTH cycles after reset release. The
        // pointer parks at its maximum instead of wrapping.
        if (ptr == PTR_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          ptr_nxt = ptr + PTR_ONE;
        end
      end
      S_IDLE: begin
        mem_we  = cs & wr;
        rd_fire = cs & rd;
      end
    endcase
  end

  // Array has no reset; contents are only defined through the clear sequence.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // The array read sees the pre-edge contents, which gives read-old-data on a
  // simultaneous write; write-first bypasses din instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      rejected   <= 1'b0;
    end else begin
      dout_valid <= rd_fire;
      rejected   <= rej_nxt;
      if (rd_fire) begin
        dout <= (RDW_MODE && wr) ? din : mem[addr];
      end
    end
  end

endmodule

// File: tb/tb_sram_sync.sv
`timescale 1ns/1ps
module tb_sram_sync;

  typedef struct {
    bit          rej;
    logic [15:0] data;
    int          due;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // group A: two 8x256 instances with clear, differing only in RDW_MODE
  logic       rst_a, cs_a, wr_a, rd_a;
  logic [7:0] addr_a, din_a;
  logic [7:0] dout0, dout1;
  logic       dv0, dv1, busy0, busy1, rej0, rej1;

  // group B: 16x16 instance without clear
  logic        rst_b, cs_b, wr_b, rd_b;
  logic [3:0]  addr_b;
  logic [15:0] din_b, dout2;
  logic        dv2, busy2, rej2;

  sram_sync #(.DATA_W(8), .ADDR_W(8), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .rst_n(rst_a), .cs(cs_a), .wr(wr_a), .rd(rd_a), .addr(addr_a), .din(din_a),
    .dout(dout0), .dout_valid(dv0), .busy(busy0), .rejected(rej0));

  sram_sync #(.DATA_W(8), .ADDR_W(8), .RDW_MODE(1'b1), .CLEAR_ON_RESET(1'b1)) u1 (
    .clk(clk), .rst_n(rst_a), .cs(cs_a), .wr(wr_a), .rd(rd_a), .addr(addr_a), .din(din_a),
    .dout(dout1), .dout_valid(dv1), .busy(busy1), .rejected(rej1));

  sram_sync #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b0)) u2 (
    .clk(clk), .rst_n(rst_b), .cs(cs_b), .wr(wr_b), .rd(rd_b), .addr(addr_b), .din(din_b),
    .dout(dout2), .dout_valid(dv2), .busy(busy2), .rejected(rej2));

  // reference model
  logic [7:0]  mem_a [256];
  logic [15:0] mem_b [16];
  int          clr_left_a = 0;
  ev_t         q [3][$];
  logic [15:0] last_d [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int i, input logic rst, input logic [15:0] d, input logic v, input logic r);
    ev_t e;
    if (!rst) begin
      q[i].delete();
      last_d[i] = '0;
      check($sformatf("reset_outputs_u%0d", i), 32'({d, v, r}), 32'h0);
      return;
    end
    if (v && r) check($sformatf("valid_and_rejected_u%0d", i), 32'h1, 32'h0);
    if (v || r) begin
      if (q[i].size() == 0) begin
        check($sformatf("unexpected_output_u%0d", i), 32'h1, 32'h0);
      end else begin
        e = q[i].pop_front();
        check($sformatf("rejected_u%0d", i), 32'(r), 32'(e.rej));
        check($sformatf("valid_u%0d", i), 32'(v), 32'(!e.rej));
        check($sformatf("latency_u%0d", i), 32'(cyc), 32'(e.due));
        if (!e.rej) last_d[i] = e.data;
      end
    end else if (q[i].size() > 0 && q[i][0].due <= cyc) begin
      e = q[i].pop_front();
      check($sformatf("missing_output_u%0d", i), 32'h0, 32'h1);
      if (!e.rej) last_d[i] = e.data;
    end
    check($sformatf("dout_u%0d", i), 32'(d), 32'(last_d[i]));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon(0, rst_a, {8'h00, dout0}, dv0, rej0);
      mon(1, rst_a, {8'h00, dout1}, dv1, rej1);
      mon(2, rst_b, dout2, dv2, rej2);
    end
  end

  // Called at a falling edge: drives one access, predicts its outcome, waits one cycle.
  task automatic step_a(input bit c, input bit w, input bit r, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    cs_a = c; wr_a = w; rd_a = r; addr_a = a; din_a = d;
    check("busy_u0", 32'(busy0), 32'(clr_left_a > 0));
    check("busy_u1", 32'(busy1), 32'(clr_left_a > 0));
    if (c && (w || r)) begin
      e.due = cyc + 1;
      if (clr_left_a > 0) begin
        e.rej = 1'b1; e.data = '0;
        q[0].push_back(e);
        q[1].push_back(e);
      end else begin
        if (r) begin
          e.rej = 1'b0;
          e.data = {8'h00, mem_a[a]};
          q[0].push_back(e);
          e.data = {8'h00, (w ? d : mem_a[a])};
          q[1].push_back(e);
        end
        if (w) mem_a[a] = d;
      end
    end
    if (clr_left_a > 0) clr_left_a--;
    @(negedge clk);
  endtask

  task automatic step_b(input bit c, input bit w, input bit r, input logic [3:0] a, input logic [15:0] d);
    ev_t e;
    cs_b = c; wr_b = w; rd_b = r; addr_b = a; din_b = d;
    check("busy_u2", 32'(busy2), 32'h0);
    if (c && r) begin
      e.rej = 1'b0; e.due = cyc + 1; e.data = mem_b[a];
      q[2].push_back(e);
    end
    if (c && w) mem_b[a] = d;
    @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b0; cs_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0;
    @(negedge clk);
    check("busy_in_reset_u0", 32'(busy0), 32'h1);
    check("busy_in_reset_u1", 32'(busy1), 32'h1);
    @(negedge clk);
    rst_a = 1'b1;
    clr_left_a = 256;
    foreach (mem_a[k]) mem_a[k] = 8'h00;
  endtask

  task automatic idle_a(input int n);
    for (int k = 0; k < n; k++) step_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    cs_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0; addr_a = '0; din_a = '0;
    cs_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; addr_b = '0; din_b = '0;
    #2;
    rst_b = 1'b0;
    @(negedge clk);
    check("busy_in_reset_u2", 32'(busy2), 32'h0);
    reset_a();
    rst_b = 1'b1;

    // full clear, then read untouched locations
    idle_a(256);
    step_a(1'b1, 1'b0, 1'b1, 8'hA5, 8'h00);
    step_a(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
    idle_a(1);

    // write then read back
    step_a(1'b1, 1'b1, 1'b0, 8'hA5, 8'hA2);
    step_a(1'b1, 1'b0, 1'b1, 8'hA5, 8'h00);
    idle_a(1);

    // deselected write and read have no effect
    step_a(1'b0, 1'b1, 1'b0, 8'h5A, 8'h5D);
    step_a(1'b1, 1'b0, 1'b1, 8'h5A, 8'h00);
    step_a(1'b0, 1'b0, 1'b1, 8'h5A, 8'h00);
    idle_a(1);

    // read-during-write
    step_a(1'b1, 1'b1, 1'b0, 8'h10, 8'h33);
    step_a(1'b1, 1'b1, 1'b1, 8'h10, 8'hC4);
    step_a(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
    idle_a(1);

    // random traffic, biased towards a small address window for reuse
    for (int k = 0; k < 400; k++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      step_a($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a, 8'($urandom));
    end
    idle_a(2);

    // access during clear, then reset mid-clear
    reset_a();
    idle_a(10);
    step_a(1'b1, 1'b0, 1'b1, 8'h33, 8'h00);
    step_a(1'b1, 1'b1, 1'b0, 8'h40, 8'h77);
    idle_a(88);
    reset_a();
    idle_a(255);
    // write attempted on the final clear edge must be refused
    step_a(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
    step_a(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    step_a(1'b1, 1'b0, 1'b1, 8'h33, 8'h00);
    idle_a(2);

    // group B: no clear, 16-bit data, back-to-back reads
    step_b(1'b1, 1'b1, 1'b0, 4'hF, 16'hBEEF);
    step_b(1'b1, 1'b1, 1'b0, 4'h0, 16'h1234);
    step_b(1'b1, 1'b0, 1'b1, 4'hF, 16'h0000);
    step_b(1'b1, 1'b0, 1'b1, 4'h0, 16'h0000);
    step_b(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
    for (int k = 1; k < 15; k++) step_b(1'b1, 1'b1, 1'b0, 4'(k), 16'($urandom));
    for (int k = 0; k < 300; k++) begin
      step_b($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom));
    end
    step_b(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
    step_b(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);

    check("pending_u0", 32'(q[0].size()), 32'h0);
    check("pending_u1", 32'(q[1].size()), 32'h0);
    check("pending_u2", 32'(q[2].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
